// File: rtl/up_down_counter.sv
// Loadable saturating up/down counter with zero and full-scale flags.
// Latency: load/step visible one cycle after the sampling edge; flags decode the register directly.
// Backpressure: none; a request is acted on every edge it is present or blocked at a limit.
module up_down_counter #(
  parameter int DATA_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_in,
  input  logic                  i_load,
  input  logic                  i_up,
  input  logic                  i_down,
  output logic [DATA_WIDTH-1:0] o_counter,
  output logic                  o_low,
  output logic                  o_high
);

  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0] count_nxt;
  logic                  at_zero;
  logic                  at_max;

  assign at_zero = (count == '0);
  assign at_max  = (count == CNT_MAX);

  // A down request at zero blocks the step rather than falling through to up.
  always_comb begin
    count_nxt = count;
    if (i_load) begin
      count_nxt = i_in;
    end else if (i_down) begin
      if (!at_zero) count_nxt = count - CNT_ONE;
    end else if (i_up) begin
      if (!at_max) count_nxt = count + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  assign o_counter = count;
  assign o_low     = at_zero;
  assign o_high    = at_max;

endmodule

// File: tb/tb_up_down_counter.sv
// Bench for up_down_counter: vector table, hand-written corner sequences and random stimulus against an arithmetic model.
module tb_up_down_counter;

  localparam int W   = 5;
  localparam int MAX = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         load;
  logic         up;
  logic         down;
  logic [W-1:0] counter;
  logic         low;
  logic         high;

  int checks = 0;
  int errors = 0;
  int model  = 0;

  up_down_counter #(.DATA_WIDTH(W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_in     (din),
    .i_load   (load),
    .i_up     (up),
    .i_down   (down),
    .o_counter(counter),
    .o_low    (low),
    .o_high   (high)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required finish before 1 ms");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit load;
    bit up;
    bit down;
    int val;
    int exp;
  } vec_t;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic check_outputs(string name);
    check({name, "_cnt"},  {27'd0, counter}, model);
    check({name, "_low"},  {31'd0, low},  (model == 0)   ? 1 : 0);
    check({name, "_high"}, {31'd0, high}, (model == MAX) ? 1 : 0);
  endtask

  // Apply inputs, take one rising edge, advance the model by the priority rules, compare.
  task automatic step(bit ld, bit u, bit d, int val, string name);
    logic [31:0] v;
    v    = val;
    load = ld;
    up   = u;
    down = d;
    din  = v[W-1:0];
    @(posedge clk);
    if (ld)          model = val;
    else if (d)      model = (model > 0) ? model - 1 : model;
    else if (u)      model = (model < MAX) ? model + 1 : model;
    #1;
    check_outputs(name);
  endtask

  vec_t tab[20];

  initial begin
    tab[0]  = '{1, 1, 0, 7,  7};
    tab[1]  = '{1, 1, 0, 7,  7};
    tab[2]  = '{0, 1, 0, 0,  8};
    tab[3]  = '{0, 1, 0, 0,  9};
    tab[4]  = '{0, 0, 0, 0,  9};
    tab[5]  = '{0, 0, 0, 0,  9};
    tab[6]  = '{0, 1, 1, 0,  8};
    tab[7]  = '{0, 0, 1, 0,  7};
    tab[8]  = '{1, 0, 0, 10, 10};
    tab[9]  = '{0, 1, 1, 0,  9};
    tab[10] = '{1, 1, 1, 3,  3};
    tab[11] = '{1, 0, 0, 0,  0};
    tab[12] = '{0, 1, 1, 0,  0};
    tab[13] = '{0, 0, 1, 0,  0};
    tab[14] = '{0, 1, 0, 0,  1};
    tab[15] = '{1, 0, 0, 31, 31};
    tab[16] = '{0, 1, 0, 0,  31};
    tab[17] = '{0, 1, 1, 0,  30};
    tab[18] = '{1, 0, 1, 31, 31};
    tab[19] = '{0, 0, 1, 0,  30};

    rst_n = 1'b1;
    din   = '0;
    load  = 1'b0;
    up    = 1'b0;
    down  = 1'b0;

    // Reset is asserted between edges and must act without a clock.
    #5 rst_n = 1'b0;
    model = 0;
    #5 check_outputs("reset_async");
    #90 check_outputs("reset_held");
    #55 rst_n = 1'b1;

    foreach (tab[i]) begin
      step(tab[i].load, tab[i].up, tab[i].down, tab[i].val, "vec");
      check("vec_table", {27'd0, counter}, tab[i].exp);
    end

    // Load 7 with up, then climb to full scale and stay there.
    step(1, 1, 0, 7, "ldup_load");
    for (int i = 0; i < 30 && counter != W'(MAX); i++) step(0, 1, 0, 0, "ldup_climb");
    check("ldup_reached_max", {27'd0, counter}, MAX);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "ldup_hold");

    // Load 7 with down, descend to zero and stay there without wrapping.
    step(1, 0, 1, 7, "lddn_load");
    for (int i = 0; i < 30 && counter != '0; i++) step(0, 0, 1, 0, "lddn_fall");
    check("lddn_reached_zero", {27'd0, counter}, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, "lddn_hold");

    // Idle holds.
    step(1, 0, 0, 13, "idle_load");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, "idle_hold");

    // Asynchronous reset mid-count, then resume from zero.
    step(1, 0, 0, 20, "arst_load");
    step(0, 0, 0, 0, "arst_pre");
    #20 rst_n = 1'b0;
    model = 0;
    #1 check_outputs("arst_mid");
    #10 rst_n = 1'b1;
    step(0, 1, 0, 0, "arst_resume");
    step(0, 1, 0, 0, "arst_resume2");

    // Random stimulus with loads kept rare so the limits get exercised.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, int'($urandom_range(0, MAX)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
